// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - stall/flush controller for the 5-stage MIPS pipeline
//
// Purpose: drives the hold/clear controls of the IF2ID, ID2EXE and EXE2MEM
// pipeline registers. Detects load-use and branch-operand hazards, tracks a
// fixed-latency mult/div unit, freezes the pipeline while data memory is not
// ready, and halts permanently if a memory wait runs past MEM_TIMEOUT.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   rs/rt/uses_rt_decode   source registers of the decode instruction
//   branch_*_decode        decode-stage branch and its comparison result
//   md_use_decode          decode instruction needs the mult/div unit
//   regwrite/memtoreg/writereg_exe, memtoreg/writereg_mem  producer info
//   md_start_exe           mult/div instruction in exe (launch request)
//   dmem_req_mem, dmem_ready  data memory handshake
//   stall_*/flush_*        pipeline register controls
//   md_busy, mem_error     mult/div running; sticky memory timeout
module hazard_sequencer #(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_decode,
  input  logic [4:0] rt_decode,
  input  logic       uses_rt_decode,
  input  logic       branch_decode,
  input  logic       branch_taken_decode,
  input  logic       md_use_decode,
  input  logic       regwrite_exe,
  input  logic       memtoreg_exe,
  input  logic [4:0] writereg_exe,
  input  logic       memtoreg_mem,
  input  logic [4:0] writereg_mem,
  input  logic       md_start_exe,
  input  logic       dmem_req_mem,
  input  logic       dmem_ready,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_decode,
  output logic       flush_exe,
  output logic       stall_exe,
  output logic       stall_mem,
  output logic       md_busy,
  output logic       mem_error
);

  localparam logic [7:0] MD_LAT  = MD_LATENCY[7:0];
  localparam logic [7:0] MEM_TMO = MEM_TIMEOUT[7:0];

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] md_cnt;

  logic match_exe, match_mem;
  logic lu_hz, br_hz, md_hz, hz, freeze, md_active;

  // Register 0 is hardwired zero, so it never creates a dependency.
  function automatic logic match(input logic [4:0] r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic use_rt);
    return (r != 5'd0) && ((r == rs) || (use_rt && (r == rt)));
  endfunction

  always_comb begin
    match_exe = match(writereg_exe, rs_decode, rt_decode, uses_rt_decode);
    match_mem = match(writereg_mem, rs_decode, rt_decode, uses_rt_decode);
    md_active = (md_cnt != 8'd0);
    lu_hz     = regwrite_exe && memtoreg_exe && match_exe;
    // Branches resolve in decode, so any in-flight producer must land first.
    br_hz     = branch_decode && ((regwrite_exe && match_exe) ||
                                  (memtoreg_mem && match_mem));
    md_hz     = md_use_decode && md_active;
    // In MEM_WAIT, dmem_ready releases the pipeline in the same cycle.
    freeze    = ((state == RUN) && dmem_req_mem && !dmem_ready) ||
                ((state == MEM_WAIT) && !dmem_ready) ||
                (state == HALT);
    hz        = (lu_hz || br_hz || md_hz) && !freeze;
  end

  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    flush_exe    = 1'b0;
    stall_exe    = 1'b0;
    stall_mem    = 1'b0;
    md_busy      = 1'b0;
    mem_error    = 1'b0;
    if (rst) begin
      md_busy   = md_active;
      mem_error = (state == HALT);
      if (freeze) begin
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        stall_exe    = 1'b1;
        stall_mem    = 1'b1;
      end else if (hz) begin
        // Hold fetch/decode and send a bubble down; a taken branch in decode
        // is simply re-evaluated next cycle.
        stall_fetch  = 1'b1;
        stall_decode = 1'b1;
        flush_exe    = 1'b1;
      end else begin
        flush_decode = branch_decode && branch_taken_decode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      md_cnt   <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req_mem && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          // Ready on the timeout cycle still releases: ready is checked first.
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == MEM_TMO) begin
            state <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase

      // A launch during busy or freeze is dropped; countdown continues
      // through freezes because the unit runs independently of the pipeline.
      if (md_start_exe && !md_active && !freeze) begin
        md_cnt <= MD_LAT;
      end else if (md_active) begin
        md_cnt <= md_cnt - 8'd1;
      end
    end
  end

endmodule
